dvsd_8216d9: RTL and testbench
==============================

# dvsd_8216d9

Sequential 16-bit by 8-bit unsigned divider. It is the inverse of the 8×8→16 multiplier: from a product M and one factor B it recovers the other factor as the quotient, with a zero remainder. It also handles arbitrary dividends, returning a 16-bit quotient and an 8-bit remainder. It uses a restoring shift-subtract datapath at one quotient bit per clock, with a start/busy/done handshake toward the requesting logic.

## Interface
- No parameters; widths fixed at 16-bit dividend and 8-bit divisor, matching the multiplier's M and A/B.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- M  input  16  dividend; captured on the accepted start edge.
- B  input  8  divisor; captured on the accepted start edge.
- Q  output  16  quotient; registered.
- R  output  8  remainder; registered.
- busy  output  1  high from the cycle after an accepted start until `done` is asserted.
- done  output  1  single-cycle pulse; Q, R and dbz are valid in this cycle.
- dbz  output  1  divide-by-zero flag; updated together with Q and R.

## Operation
- States:
  - IDLE → LOAD action on `start`: capture M into the dividend shift register and B into the divisor register.
    - B≠0: clear the 9-bit partial remainder, set cnt=0, go to DIV.
    - B==0: go to DONE directly.
- DIV, one iteration per edge:
  - rem9 = {rem[7:0], dvd[15]}; shift dvd left.
  - If rem9 ≥ {1'b0,div}: rem = rem9 − div and shift in quotient bit 1.
  - Else: rem = rem9 and shift in quotient bit 0.
  - cnt increments. On the edge with cnt==15, load Q and R and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE.
- Arithmetic:
  - The partial remainder is 9 bits so the compare never overflows (rem<div≤255, shifted ≤511).
  - The final R = rem[7:0] always satisfies R < B.
- Divide by zero: Q=16'hFFFF, R=8'hFF, dbz=1.
- dbz=0 for every nonzero-divisor result.
- Q/R/dbz hold their last result until the next result is loaded; they do not clear in IDLE.
- start while busy or in DONE: ignored and not queued. M and B may change freely after the accepting edge.

## Timing
- Reset values: Q=0, R=0, busy=0, done=0, dbz=0; state=IDLE, cnt=0, internal registers 0.
- Reset mid-operation: the divider returns immediately to IDLE with all of the above values, and no done pulse is produced for the aborted request.
- Nonzero divisor:
  - Accepting edge E0: busy=1 after E0.
  - DIV edges E1..E16: Q/R are loaded at E16.
  - After E16: done=1 and busy=0 for one cycle.
  - Latency is start-edge to done-cycle = 16 cycles.
- Zero divisor: accepting edge E0; done=1, busy=0 after E1; latency 1 cycle.
- Throughput: the earliest next start is sampled in the cycle after the done pulse (IDLE). One result per 18 cycles back-to-back.
- busy and done are never high simultaneously.

## Test plan
- M=16'hFE01, B=8'hFF (255×255) → after 16 cycles: done pulse, Q=16'h00FF, R=0, dbz=0.
- M=16'hFFFF, B=8'h01 → Q=16'hFFFF, R=0; M=16'hFFFF, B=8'hFF → Q=16'h0101, R=0.
- M=1000, B=7 → Q=142, R=6. Then M=5, B=9 → Q=0, R=5. Random sweep: Q*B+R==M and R<B every time.
- B=0, M=16'h1234 → done one cycle after the accepting edge, Q=16'hFFFF, R=8'hFF, dbz=1. The following M=16, B=4 → Q=4, R=0, dbz=0.
- start held high and M/B changed during busy → result matches only the first capture; exactly one done pulse per accepted start.
- rst_n pulled low at DIV cycle 8 → all outputs 0 immediately and no done pulse. A fresh start after release gives a correct result at nominal latency.

Source files
------------

// File: rtl/dvsd_8216d9.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero yields all-ones with dbz set.
module dvsd_8216d9 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] M,
  input  logic [7:0]  B,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        busy,
  output logic        done,
  output logic        dbz
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] dvd;
  logic [7:0]  div;
  logic [7:0]  rem;
  logic [3:0]  cnt;
  logic [8:0]  rem9;
  logic [7:0]  diff;
  logic        qbit;

  // rem < div always holds, so the true difference fits in 8 bits
  always_comb begin
    rem9 = {rem, dvd[15]};
    qbit = (rem9 >= {1'b0, div});
    diff = rem9[7:0] - div;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = DIV;
      DIV: begin
        if (div == 8'd0 || cnt == 4'd15)
          state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == DIV);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= '0;
      div   <= '0;
      rem   <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      dbz   <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd <= M;
            div <= B;
            rem <= '0;
            cnt <= '0;
          end
        end
        DIV: begin
          if (div == 8'd0) begin
            Q   <= 16'hFFFF;
            R   <= 8'hFF;
            dbz <= 1'b1;
          end else begin
            rem <= qbit ? diff : rem9[7:0];
            dvd <= {dvd[14:0], qbit};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              Q   <= {dvd[14:0], qbit};
              R   <= qbit ? diff : rem9[7:0];
              dbz <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dvsd_8216d9.sv
// Bench for dvsd_8216d9: arithmetic model, per-cycle monitor,
// directed vectors with literal expectations.
module tb_dvsd_8216d9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] M = '0;
  logic [7:0]  B = '0;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        busy;
  logic        done;
  logic        dbz;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [15:0] exp_q = '0;
  logic [7:0]  exp_r = '0;
  logic        exp_z = 1'b0;

  dvsd_8216d9 dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .M(M), .B(B), .Q(Q), .R(R),
    .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Outputs hold between results; busy and done are exclusive
  always @(negedge clk) begin
    if (done) done_cnt++;
    chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
    if (!done) begin
      chk("hold_q", {16'd0, Q}, {16'd0, exp_q});
      chk("hold_r", {24'd0, R}, {24'd0, exp_r});
      chk("hold_dbz", {31'd0, dbz}, {31'd0, exp_z});
    end
  end

  // Runs one division (start optionally held with M/B scrambled)
  task automatic run_op(input logic [15:0] m, input logic [7:0] b,
                        input bit hold, output logic [15:0] q,
                        output logic [7:0] r);
    logic [15:0] mq;
    logic [7:0]  mr;
    logic        mz;
    int          n;
    bit          seen;
    if (b == 0) begin
      mq = 16'hFFFF; mr = 8'hFF; mz = 1'b1;
    end else begin
      mq = m / {8'd0, b};
      mr = 8'(m % {8'd0, b});
      mz = 1'b0;
    end
    M = m; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    n = 0;
    seen = 0;
    while (n < 40) begin
      @(negedge clk);
      if (n == 0) chk("busy_after_start", {31'd0, busy}, 32'd1);
      if (done) begin
        seen = 1;
        break;
      end
      if (hold) begin
        M = M + 16'h1357;
        B = B + 8'd3;
      end
      @(posedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("latency", n, (b == 0) ? 32'd1 : 32'd16);
    chk("q_model", {16'd0, Q}, {16'd0, mq});
    chk("r_model", {24'd0, R}, {24'd0, mr});
    chk("dbz_model", {31'd0, dbz}, {31'd0, mz});
    if (b != 0) begin
      chk("qb_plus_r", 32'(Q) * 32'(b) + 32'(R), 32'(m));
      chk("r_lt_b", {31'd0, R < b}, 32'd1);
    end
    q = Q;
    r = R;
    exp_q = mq; exp_r = mr; exp_z = mz;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] q;
    logic [7:0]  r;
    int          dc;
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_q", {16'd0, Q}, 32'd0);
    chk("reset_r", {24'd0, R}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dbz", {31'd0, dbz}, 32'd0);

    run_op(16'hFE01, 8'hFF, 0, q, r);
    chk("lit_fe01_q", {16'd0, q}, 32'h00FF);
    chk("lit_fe01_r", {24'd0, r}, 32'h0);
    run_op(16'hFFFF, 8'h01, 0, q, r);
    chk("lit_ffff1_q", {16'd0, q}, 32'hFFFF);
    chk("lit_ffff1_r", {24'd0, r}, 32'h0);
    run_op(16'hFFFF, 8'hFF, 0, q, r);
    chk("lit_ffffff_q", {16'd0, q}, 32'h0101);
    chk("lit_ffffff_r", {24'd0, r}, 32'h0);
    run_op(16'd1000, 8'd7, 0, q, r);
    chk("lit_1000_q", {16'd0, q}, 32'd142);
    chk("lit_1000_r", {24'd0, r}, 32'd6);
    run_op(16'd5, 8'd9, 0, q, r);
    chk("lit_5_q", {16'd0, q}, 32'd0);
    chk("lit_5_r", {24'd0, r}, 32'd5);
    run_op(16'h1234, 8'd0, 0, q, r);
    chk("lit_dbz_q", {16'd0, q}, 32'hFFFF);
    chk("lit_dbz_r", {24'd0, r}, 32'hFF);
    chk("lit_dbz_flag", {31'd0, dbz}, 32'd1);
    run_op(16'd16, 8'd4, 0, q, r);
    chk("lit_16_q", {16'd0, q}, 32'd4);
    chk("lit_16_r", {24'd0, r}, 32'd0);
    chk("lit_16_dbz", {31'd0, dbz}, 32'd0);

    for (int i = 0; i < 12; i++)
      run_op(16'($urandom), 8'($urandom_range(1, 255)), 0, q, r);

    dc = done_cnt;
    run_op(16'd300, 8'd7, 1, q, r);
    chk("lit_hold_q", {16'd0, q}, 32'd42);
    chk("lit_hold_r", {24'd0, r}, 32'd6);
    repeat (3) @(posedge clk);
    #1;
    chk("one_done_per_start", done_cnt - dc, 32'd1);

    M = 16'd40000; B = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q = '0; exp_r = '0; exp_z = 1'b0;
    #1;
    chk("abort_q", {16'd0, Q}, 32'd0);
    chk("abort_r", {24'd0, R}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_dbz", {31'd0, dbz}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    dc = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt - dc, 32'd0);
    run_op(16'd40000, 8'd3, 0, q, r);
    chk("lit_post_reset_q", {16'd0, q}, 32'd13333);
    chk("lit_post_reset_r", {24'd0, r}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
